// File: rtl/mrr_burst_detect.sv
// mrr_burst_detect
//   Energy-based burst gate between the AD9361 RX channel-0 I/Q stream and
//   mrr_gateway. A 16-sample (2^LOG2_WIN) moving average of |I|+|Q| is
//   compared with a programmable threshold. Samples inside a detected burst
//   are forwarded with start/end flags. A hang time keeps the burst open
//   across short dips. A length cap force-closes a burst that runs too long.
//
//   Pipeline: S1 magnitude, S2 window sum, S3 compare + state + output regs.
//   Latency from in_valid to out_valid is fixed at 3 clk. The pipeline never
//   stalls.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   enable        detector enable (quasi-static)
//   threshold     unsigned average-magnitude threshold (hi = avg > threshold)
//   in_valid/in_i/in_q         input sample stream (signed I/Q)
//   out_valid/out_i/out_q      gated sample stream (I/Q hold between valids)
//   out_sof/out_eof            first/last sample of burst (with out_valid)
//   out_abort     1-clk pulse when a burst is cut off by enable going low
//   burst_active  high while a burst is open (ACTIVE or HANG)
//   burst_count   completed bursts (eof emitted), wraps at 16 bits
//   out_peak      (only with MRR_BURST_DETECT_PEAK_EN) max |I|+|Q| over the
//                 emitted samples of the current/last burst
//
// Build option: define MRR_BURST_DETECT_PEAK_EN to add the out_peak port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no burst; waiting for the average to go above threshold
// ACTIVE   | burst open, average above threshold
// HANG     | burst open, average below threshold, counting hang samples
// WAIT_LOW | burst force-closed at MAX_LEN; wait for average to drop
module mrr_burst_detect #(
  parameter int LOG2_WIN = 4,
  parameter int HANG     = 8,
  parameter int MAX_LEN  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] threshold,
  input  logic        in_valid,
  input  logic [15:0] in_i,
  input  logic [15:0] in_q,
  output logic        out_valid,
  output logic [15:0] out_i,
  output logic [15:0] out_q,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_abort,
  output logic        burst_active,
  output logic [15:0] burst_count
`ifdef MRR_BURST_DETECT_PEAK_EN
  ,
  output logic [16:0] out_peak
`endif
);

  localparam int WIN    = 1 << LOG2_WIN;
  localparam int SUM_W  = 17 + LOG2_WIN;
  localparam int HANG_W = $clog2(HANG + 1);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HANG,
    ST_WAIT_LOW
  } state_t;

  // ---------------- S1: magnitude ----------------
  // Sign-extend to 17 bits before negating so |-32768| = 32768 is exact.
  logic [16:0] abs_i, abs_q, mag_s1;
  assign abs_i  = in_i[15] ? (17'd0 - {in_i[15], in_i}) : {1'b0, in_i};
  assign abs_q  = in_q[15] ? (17'd0 - {in_q[15], in_q}) : {1'b0, in_q};
  assign mag_s1 = abs_i + abs_q;

  logic        v1;
  logic [15:0] i1, q1;
  logic [16:0] mag1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      i1   <= '0;
      q1   <= '0;
      mag1 <= '0;
    end else begin
      v1   <= in_valid;
      i1   <= in_i;
      q1   <= in_q;
      mag1 <= mag_s1;
    end
  end

  // ---------------- S2: running window sum ----------------
  // The delay line and the sum advance only on valid samples, so the
  // window is WIN samples regardless of the input duty cycle.
  logic             v2;
  logic [15:0]      i2, q2;
  logic [SUM_W-1:0] sum;
  logic [16:0]      dline [WIN];
`ifdef MRR_BURST_DETECT_PEAK_EN
  logic [16:0]      mag2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      i2  <= '0;
      q2  <= '0;
      sum <= '0;
      for (int k = 0; k < WIN; k++) dline[k] <= '0;
`ifdef MRR_BURST_DETECT_PEAK_EN
      mag2 <= '0;
`endif
    end else begin
      v2 <= v1;
      i2 <= i1;
      q2 <= q1;
`ifdef MRR_BURST_DETECT_PEAK_EN
      mag2 <= mag1;
`endif
      if (v1) begin
        sum      <= sum + SUM_W'(mag1) - SUM_W'(dline[WIN-1]);
        dline[0] <= mag1;
        for (int k = 1; k < WIN; k++) dline[k] <= dline[k-1];
      end
    end
  end

  // ---------------- S3: compare, state, outputs ----------------
  logic [31:0] avg;
  logic        hi;
  assign avg = 32'(sum >> LOG2_WIN);
  assign hi  = (avg > threshold);

  state_t            state_q, state_n;
  logic [HANG_W-1:0] hang_q, hang_n, hang_inc;
  logic [LEN_W-1:0]  len_q, len_n, len_inc;
  logic              hang_done, len_max;
  logic              ov_n, sof_n, eof_n, abort_n;
  logic [15:0]       oi_n, oq_n, cnt_n;
`ifdef MRR_BURST_DETECT_PEAK_EN
  logic [16:0]       peak_q, peak_n;
  assign out_peak = peak_q;
`endif

  // hang_q is held at 0 in ACTIVE, so hang_inc is 1 on the first low sample
  // out of ACTIVE and HANG=1 closes on that sample.
  assign hang_inc  = hang_q + HANG_W'(1);
  assign hang_done = (hang_inc == HANG_W'(HANG));
  assign len_inc   = len_q + LEN_W'(1);
  assign len_max   = (len_inc == LEN_W'(MAX_LEN));

  always_comb begin
    state_n = state_q;
    hang_n  = hang_q;
    len_n   = len_q;
    ov_n    = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    abort_n = 1'b0;
    oi_n    = out_i;
    oq_n    = out_q;
    cnt_n   = burst_count;
`ifdef MRR_BURST_DETECT_PEAK_EN
    peak_n  = peak_q;
`endif
    if (!enable) begin
      if (state_q == ST_ACTIVE || state_q == ST_HANG) abort_n = 1'b1;
      state_n = ST_IDLE;
      hang_n  = '0;
      len_n   = '0;
    end else if (v2) begin
      case (state_q)
        ST_IDLE: begin
          if (hi) begin
            state_n = ST_ACTIVE;
            ov_n    = 1'b1;
            sof_n   = 1'b1;
            oi_n    = i2;
            oq_n    = q2;
            len_n   = LEN_W'(1);
            hang_n  = '0;
`ifdef MRR_BURST_DETECT_PEAK_EN
            peak_n  = mag2;
`endif
          end
        end
        ST_ACTIVE, ST_HANG: begin
          ov_n  = 1'b1;
          oi_n  = i2;
          oq_n  = q2;
          len_n = len_inc;
`ifdef MRR_BURST_DETECT_PEAK_EN
          peak_n = (mag2 > peak_q) ? mag2 : peak_q;
`endif
          if (hi) begin
            state_n = ST_ACTIVE;
            hang_n  = '0;
          end else begin
            state_n = ST_HANG;
            hang_n  = hang_inc;
          end
          if (len_max || (!hi && hang_done)) begin
            eof_n   = 1'b1;
            cnt_n   = burst_count + 16'd1;
            hang_n  = '0;
            len_n   = '0;
            // A capped burst with the signal still up must not restart
            // immediately; it waits for the average to drop first.
            state_n = (len_max && hi) ? ST_WAIT_LOW : ST_IDLE;
          end
        end
        ST_WAIT_LOW: begin
          if (!hi) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hang_q      <= '0;
      len_q       <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_abort   <= 1'b0;
      out_i       <= '0;
      out_q       <= '0;
      burst_count <= '0;
`ifdef MRR_BURST_DETECT_PEAK_EN
      peak_q      <= '0;
`endif
    end else begin
      state_q     <= state_n;
      hang_q      <= hang_n;
      len_q       <= len_n;
      out_valid   <= ov_n;
      out_sof     <= sof_n;
      out_eof     <= eof_n;
      out_abort   <= abort_n;
      out_i       <= oi_n;
      out_q       <= oq_n;
      burst_count <= cnt_n;
`ifdef MRR_BURST_DETECT_PEAK_EN
      peak_q      <= peak_n;
`endif
    end
  end

  assign burst_active = (state_q == ST_ACTIVE) || (state_q == ST_HANG);

endmodule

// File: tb/tb_mrr_burst_detect.sv
// Bench for mrr_burst_detect: two instances (MAX_LEN 4096 and 32) share one
// stimulus stream; a sample-level reference model predicts every output.
module tb_mrr_burst_detect;

  localparam int HANG_N = 8;
  localparam int WIN_N  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] threshold;
  logic        in_valid;
  logic [15:0] in_i, in_q;

  logic        ov [2];
  logic        osof [2];
  logic        oeof [2];
  logic        oab [2];
  logic        oact [2];
  logic [15:0] oi [2];
  logic [15:0] oq [2];
  logic [15:0] ocnt [2];
`ifdef MRR_BURST_DETECT_PEAK_EN
  logic [16:0] opk [2];
`endif

  always #5 clk = ~clk;

  mrr_burst_detect #(.LOG2_WIN(4), .HANG(8), .MAX_LEN(4096)) dut (
    .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
    .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_valid(ov[0]), .out_i(oi[0]), .out_q(oq[0]),
    .out_sof(osof[0]), .out_eof(oeof[0]), .out_abort(oab[0]),
    .burst_active(oact[0]), .burst_count(ocnt[0])
`ifdef MRR_BURST_DETECT_PEAK_EN
    , .out_peak(opk[0])
`endif
  );

  mrr_burst_detect #(.LOG2_WIN(4), .HANG(8), .MAX_LEN(32)) dut_ml (
    .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
    .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_valid(ov[1]), .out_i(oi[1]), .out_q(oq[1]),
    .out_sof(osof[1]), .out_eof(oeof[1]), .out_abort(oab[1]),
    .burst_active(oact[1]), .burst_count(ocnt[1])
`ifdef MRR_BURST_DETECT_PEAK_EN
    , .out_peak(opk[1])
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          in_burst;
    bit          wait_low;
    int          low_run;
    int          len;
    bit          ov, sof, eof, abort;
    logic [15:0] oi, oq;
    int          cnt;
    int          peak;
  } mst_t;

  mst_t        m [2];
  int          max_len [2] = '{4096, 32};
  bit          pv [2];
  logic [15:0] pi [2];
  logic [15:0] pq [2];
  int          hist [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_in, mark_k, mark_cyc;
  int nv [2], nsof [2], neof [2], nab [2], sof_nv [2], sof_cyc [2], eof_len [2];
  int pk_eof [2];

  function automatic mst_t mclear();
    mst_t s;
    s.in_burst = 0; s.wait_low = 0; s.low_run = 0; s.len = 0;
    s.ov = 0; s.sof = 0; s.eof = 0; s.abort = 0;
    s.oi = '0; s.oq = '0; s.cnt = 0; s.peak = 0;
    return s;
  endfunction

  function automatic int magf(logic [15:0] x, logic [15:0] y);
    int a, b;
    a = $signed(x);
    b = $signed(y);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return a + b;
  endfunction

  // One processed sample (or idle cycle) of the burst rules.
  function automatic mst_t mstep(mst_t s, bit en, bit v, logic [15:0] i, logic [15:0] q,
                                 int mag, bit hi, int maxl);
    s.ov = 0; s.sof = 0; s.eof = 0; s.abort = 0;
    if (!en) begin
      s.abort = s.in_burst;
      s.in_burst = 0; s.wait_low = 0; s.low_run = 0; s.len = 0;
      return s;
    end
    if (!v) return s;
    if (s.wait_low) begin
      if (!hi) s.wait_low = 0;
      return s;
    end
    if (!s.in_burst) begin
      if (hi) begin
        s.in_burst = 1; s.len = 1; s.low_run = 0;
        s.ov = 1; s.sof = 1; s.oi = i; s.oq = q; s.peak = mag;
      end
      return s;
    end
    s.ov = 1; s.oi = i; s.oq = q;
    s.len = s.len + 1;
    if (mag > s.peak) s.peak = mag;
    s.low_run = hi ? 0 : s.low_run + 1;
    if (s.len == maxl || s.low_run == HANG_N) begin
      s.eof = 1;
      s.cnt = (s.cnt + 1) % 65536;
      s.in_burst = 0;
      s.wait_low = hi;
      s.low_run = 0;
      s.len = 0;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) m[d] = mclear();
    for (int k = 0; k < 2; k++) begin
      pv[k] = 0; pi[k] = '0; pq[k] = '0;
    end
    hist.delete();
  endtask

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk("out_valid", d, 32'(ov[d]), 32'(m[d].ov));
      chk("out_sof", d, 32'(osof[d]), 32'(m[d].sof));
      chk("out_eof", d, 32'(oeof[d]), 32'(m[d].eof));
      chk("out_abort", d, 32'(oab[d]), 32'(m[d].abort));
      chk("burst_active", d, 32'(oact[d]), 32'(m[d].in_burst));
      chk("burst_count", d, 32'(ocnt[d]), 32'(m[d].cnt));
      chk("out_i", d, 32'(oi[d]), 32'(m[d].oi));
      chk("out_q", d, 32'(oq[d]), 32'(m[d].oq));
`ifdef MRR_BURST_DETECT_PEAK_EN
      chk("out_peak", d, 32'(opk[d]), 32'(m[d].peak));
`endif
    end
  endtask

  task automatic clear_tallies();
    n_in = 0; mark_k = -1; mark_cyc = 0;
    for (int d = 0; d < 2; d++) begin
      nv[d] = 0; nsof[d] = 0; neof[d] = 0; nab[d] = 0;
      sof_nv[d] = 0; sof_cyc[d] = 0; eof_len[d] = 0; pk_eof[d] = 0;
    end
  endtask

  task automatic tally();
    for (int d = 0; d < 2; d++) begin
      if (ov[d]) nv[d]++;
      if (ov[d] && osof[d]) begin
        nsof[d]++; sof_nv[d] = nv[d]; sof_cyc[d] = cyc + 1;
      end
      if (ov[d] && oeof[d]) begin
        neof[d]++; eof_len[d] = nv[d] - sof_nv[d] + 1;
`ifdef MRR_BURST_DETECT_PEAK_EN
        pk_eof[d] = int'(opk[d]);
`endif
      end
      if (oab[d]) nab[d]++;
    end
  endtask

  // Advance one clock: model sees the same inputs the DUT samples, then
  // all outputs are checked at the falling edge.
  task automatic tick();
    bit          s3v, hi;
    logic [15:0] s3i, s3q;
    int          mag, sum, avg;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      s3v = pv[1]; s3i = pi[1]; s3q = pq[1];
      pv[1] = pv[0]; pi[1] = pi[0]; pq[1] = pq[0];
      pv[0] = in_valid; pi[0] = in_i; pq[0] = in_q;
      mag = magf(s3i, s3q);
      hi = 0;
      if (s3v) begin
        hist.push_back(mag);
        if (hist.size() > WIN_N) void'(hist.pop_front());
        sum = 0;
        foreach (hist[k]) sum += hist[k];
        avg = sum / WIN_N;
        hi = ($unsigned(avg) > threshold);
      end
      for (int d = 0; d < 2; d++)
        m[d] = mstep(m[d], enable, s3v, s3i, s3q, mag, hi, max_len[d]);
    end
    @(negedge clk);
    compare_all();
    tally();
  endtask

  task automatic send(int n, logic [15:0] i, logic [15:0] q, bit gap = 0);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_i = i; in_q = q;
      n_in++;
      if (n_in == mark_k) mark_cyc = cyc + 1;
      tick();
      if (gap) begin
        in_valid = 1'b0; in_i = 16'h5A5A; in_q = 16'hA5A5;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    clear_tallies();
    #1 compare_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; threshold = 32'd25;
    in_valid = 1'b0; in_i = '0; in_q = '0;
    model_reset();
    clear_tallies();
    @(negedge clk);
    compare_all();
    chk("reset_count", 0, 32'(ocnt[0]), 32'd0);
    chk("reset_valid", 0, 32'(ov[0]), 32'd0);
    rst = 1'b0;

    // Idle: zeros never open a burst
    do_reset();
    threshold = 32'd25;
    send(30, 16'd0, 16'd0);
    chk("idle_nvalid", 0, 32'(nv[0]), 32'd0);
    chk("idle_count", 0, 32'(ocnt[0]), 32'd0);

    // Basic burst with hang: avg first > 25 on sample 5, first low on 52
    do_reset();
    mark_k = 5;
    send(40, 16'd100, 16'd0);
    send(30, 16'd0, 16'd0);
    chk("sof_latency", 0, 32'(sof_cyc[0] - mark_cyc), 32'd3);
    chk("burst_len", 0, 32'(eof_len[0]), 32'd55);
    chk("burst_nsof", 0, 32'(nsof[0]), 32'd1);
    chk("burst_count", 0, 32'(ocnt[0]), 32'd1);

    // Re-trigger inside hang, with idle cycles between samples
    do_reset();
    send(40, 16'd100, 16'd0, 1);
    send(12, 16'd0, 16'd0, 1);
    send(40, 16'd100, 16'd0, 1);
    send(30, 16'd0, 16'd0, 1);
    chk("retrig_nsof", 0, 32'(nsof[0]), 32'd1);
    chk("retrig_neof", 0, 32'(neof[0]), 32'd1);
    chk("retrig_len", 0, 32'(eof_len[0]), 32'd107);
    chk("retrig_count", 0, 32'(ocnt[0]), 32'd1);

    // Length cap on the MAX_LEN=32 instance
    do_reset();
    send(60, 16'd1000, 16'd0);
    chk("cap_len", 1, 32'(eof_len[1]), 32'd32);
    chk("cap_nvalid", 1, 32'(nv[1]), 32'd32);
    chk("cap_count1", 1, 32'(ocnt[1]), 32'd1);
    send(20, 16'd0, 16'd0);
    chk("cap_waitlow", 1, 32'(nv[1]), 32'd32);
    send(40, 16'd1000, 16'd0);
    send(20, 16'd0, 16'd0);
    chk("cap_nsof", 1, 32'(nsof[1]), 32'd2);
    chk("cap_nvalid2", 1, 32'(nv[1]), 32'd64);
    chk("cap_count2", 1, 32'(ocnt[1]), 32'd2);

    // Abort by dropping enable mid-burst
    do_reset();
    send(30, 16'd1000, 16'd0);
    begin
      int nv_before;
      nv_before = nv[0];
      enable = 1'b0;
      send(6, 16'd1000, 16'd0);
      chk("abort_pulses", 0, 32'(nab[0]), 32'd1);
      chk("abort_pulses", 1, 32'(nab[1]), 32'd1);
      chk("abort_count", 0, 32'(ocnt[0]), 32'd0);
      chk("abort_neof", 0, 32'(neof[0]), 32'd0);
      chk("disabled_valid", 0, 32'(nv[0] - nv_before), 32'd0);
    end
    enable = 1'b1;
    send(20, 16'd1000, 16'd0);
    send(30, 16'd0, 16'd0);
    chk("abort_resume_count", 0, 32'(ocnt[0]), 32'd1);
    chk("abort_resume_nsof", 0, 32'(nsof[0]), 32'd2);

    // Full-scale magnitude: avg = 65536, strict compare, threshold change
    do_reset();
    threshold = 32'd65536;
    send(40, 16'h8000, 16'h8000);
    chk("fs_no_burst", 0, 32'(nv[0]), 32'd0);
    threshold = 32'd65535;
    send(40, 16'h8000, 16'h8000);
    chk("fs_active", 0, 32'(oact[0]), 32'd1);
    chk("fs_cap_neof", 1, 32'(neof[1]), 32'd1);
    chk("fs_cap_len", 1, 32'(eof_len[1]), 32'd32);
`ifdef MRR_BURST_DETECT_PEAK_EN
    chk("fs_peak", 1, 32'(pk_eof[1]), 32'd65536);
`endif
    // reset in the middle of an open burst clears everything at once
    do_reset();
    chk("midrst_active", 0, 32'(oact[0]), 32'd0);
    chk("midrst_count", 0, 32'(ocnt[0]), 32'd0);

    // Threshold boundary with mixed-sign samples: |-10|+|15| = 25
    do_reset();
    threshold = 32'd25;
    send(30, 16'hFFF6, 16'd15);
    chk("thr_equal", 0, 32'(nv[0]), 32'd0);
    threshold = 32'd24;
    send(10, 16'hFFF6, 16'd15);
    send(30, 16'd0, 16'd0);
    chk("thr_nsof", 0, 32'(nsof[0]), 32'd1);
    chk("thr_count", 0, 32'(ocnt[0]), 32'd1);

    send(5, 16'd0, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
